// File: rtl/weather_pkg.sv
// rtl/weather_pkg.sv - shared types and constants for the weather SPI initiator
// Optional build macro: WX_CHECKSUM_EN (adds an XOR checksum byte to each frame).
package weather_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } wx_state_t;

`ifdef WX_CHECKSUM_EN
  localparam int WX_FRAME_BYTES = 4;
`else
  localparam int WX_FRAME_BYTES = 3;
`endif

  localparam logic [7:0] WX_CMD_BYTE = 8'hA5;

  function automatic logic [7:0] wx_flags_byte(input logic too_windy, input logic water);
    return {6'b0, too_windy, water};
  endfunction

endpackage

// File: rtl/weather_spi_master_tick_gen.sv
// rtl/weather_spi_master_tick_gen.sv - SCLK half-period enable, restarted on every FSM state change
module spi_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic ms_clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  always_ff @(posedge ms_clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (restart || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + W'(1);
    end
  end

endmodule

// File: rtl/weather_spi_master.sv
// rtl/weather_spi_master.sv - SPI mode-0 initiator sending one weather-report frame per start pulse
// Build macro WX_CHECKSUM_EN appends an XOR checksum byte; default build sends three bytes.
module weather_spi_master
  import weather_pkg::*;
#(
  parameter int         CLK_DIV  = 1,
  parameter logic [7:0] CMD_BYTE = WX_CMD_BYTE
) (
  input  logic       ms_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wind_speed,
  input  logic       water,
  input  logic       too_windy,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(WX_FRAME_BYTES - 1);

  wx_state_t  state, next_state;
  logic       tick;
  logic       restart;
  logic [7:0] wind_q;
  logic [7:0] flags_q;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] next_byte;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic       last_bit;

  assign last_bit = (byte_cnt == LAST_BYTE) && (bit_cnt == 3'd7);
  assign restart  = (next_state != state);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .ms_clk (ms_clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

`ifdef WX_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = CMD_BYTE ^ wind_q ^ flags_q;
`endif

  // Byte that follows the one currently in tx_shift.
  always_comb begin
    next_byte = 8'h00;
    case (byte_cnt)
      2'd0:    next_byte = wind_q;
      2'd1:    next_byte = flags_q;
`ifdef WX_CHECKSUM_EN
      2'd2:    next_byte = checksum;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge ms_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETUP;
      SETUP:   if (tick)  next_state = HIGH;
      HIGH:    if (tick)  next_state = LOW;
      LOW:     if (tick)  next_state = last_bit ? HOLD : HIGH;
      HOLD:    if (tick)  next_state = GAP;
      GAP:     if (tick)  next_state = IDLE;
      default:            next_state = IDLE;
    endcase
  end

  always_comb begin
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    busy = 1'b1;
    case (state)
      IDLE: busy = 1'b0;
      SETUP, LOW: begin
        cs_n = 1'b0;
        mosi = tx_shift[7];
      end
      HIGH: begin
        cs_n = 1'b0;
        sclk = 1'b1;
        mosi = tx_shift[7];
      end
      HOLD:    cs_n = 1'b0;
      GAP:     cs_n = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Rx samples on each entry to HIGH; tx advances on each entry to LOW.
  always_ff @(posedge ms_clk or negedge reset) begin
    if (!reset) begin
      wind_q   <= 8'h00;
      flags_q  <= 8'h00;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      rx_byte  <= 8'h00;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wind_q   <= wind_speed;
            flags_q  <= wx_flags_byte(too_windy, water);
            tx_shift <= CMD_BYTE;
            rx_shift <= 8'h00;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
          end
        end
        SETUP: begin
          if (tick) rx_shift <= {rx_shift[6:0], miso};
        end
        HIGH: begin
          if (tick) tx_shift <= (bit_cnt == 3'd7) ? next_byte : {tx_shift[6:0], 1'b0};
        end
        LOW: begin
          if (tick) begin
            if (!last_bit) rx_shift <= {rx_shift[6:0], miso};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
          end
        end
        GAP: begin
          if (tick) begin
            done     <= 1'b1;
            rx_valid <= 1'b1;
            rx_byte  <= rx_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weather_spi_master.sv
// tb/tb_weather_spi_master.sv - directed self-checking bench for weather_spi_master
module tb_weather_spi_master;
  import weather_pkg::*;

  localparam int N = WX_FRAME_BYTES;

  logic       ms_clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] wind_speed = 8'd0;
  logic       water = 1'b0;
  logic       too_windy = 1'b0;
  logic       miso;
  logic       miso3 = 1'b0;
  logic       sclk, mosi, cs_n, busy, done, rx_valid;
  logic [7:0] rx_byte;
  logic       sclk3, mosi3, cs_n3, busy3, done3, rx_valid3;
  logic [7:0] rx_byte3;

  int checks = 0;
  int errors = 0;

  logic [31:0] f_bits;
  int f_busy, f_dones, f_rxv_bad, f_mosi_bad;
  logic f_rxv, f_cs_done;

  always #5 ms_clk = ~ms_clk;

  weather_spi_master #(.CLK_DIV(1)) dut (
    .ms_clk(ms_clk), .reset(reset), .start(start), .wind_speed(wind_speed),
    .water(water), .too_windy(too_windy), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .busy(busy), .done(done), .rx_byte(rx_byte), .rx_valid(rx_valid)
  );

  weather_spi_master #(.CLK_DIV(3)) dut3 (
    .ms_clk(ms_clk), .reset(reset), .start(start3), .wind_speed(wind_speed),
    .water(water), .too_windy(too_windy), .miso(miso3), .sclk(sclk3), .mosi(mosi3),
    .cs_n(cs_n3), .busy(busy3), .done(done3), .rx_byte(rx_byte3), .rx_valid(rx_valid3)
  );

  // Peer replies zeros then 0x3C in the final byte, shifting on falling sclk.
  logic [31:0] peer_frame = 32'h0000_003C;
  int peer_idx = 0;
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) peer_idx <= 0;
    else      peer_idx <= peer_idx + 1;
  end
  assign miso = (!cs_n && peer_idx < 8 * N) ? peer_frame[8 * N - 1 - peer_idx] : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_frame(input logic [7:0] ws, input logic wt, input logic tw);
    logic [7:0] b2;
    b2 = {6'b0, tw, wt};
    if (N == 4) return {8'hA5, ws, b2, 8'hA5 ^ ws ^ b2};
    return {8'h00, 8'hA5, ws, b2};
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or budget expiry).
  task automatic send_frame(input bit poke);
    bit prev;
    prev = 1'b0;
    f_bits = 32'h0; f_busy = 0; f_dones = 0; f_rxv_bad = 0; f_mosi_bad = 0;
    f_rxv = 1'b0; f_cs_done = 1'b0;
    start = 1'b1;
    @(negedge ms_clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (busy) f_busy++;
      if (cs_n && mosi) f_mosi_bad++;
      if (sclk && !prev) f_bits = {f_bits[30:0], mosi};
      prev = sclk;
      if (poke && cyc == 10) begin
        start = 1'b1;
        wind_speed = 8'd99;
      end
      if (poke && cyc == 11) start = 1'b0;
      if (done) begin
        f_dones++;
        f_rxv = rx_valid;
        f_cs_done = cs_n;
        break;
      end
      if (rx_valid) f_rxv_bad++;
      @(negedge ms_clk);
    end
  endtask

  task automatic idle_watch(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge ms_clk);
      if (done || busy || rx_valid) hits++;
    end
  endtask

  initial begin
    int hits, b3, d3, r0, r1, nr, m3;
    bit p3;

    repeat (3) @(negedge ms_clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    reset = 1'b1;
    @(negedge ms_clk);
    check("post_rst_busy", busy, 1'b0);

    wind_speed = 8'd37; water = 1'b0; too_windy = 1'b1;
    send_frame(1'b0);
    check("s2_bits", f_bits, exp_frame(8'd37, 1'b0, 1'b1));
    check("s2_busy_cycles", f_busy, 16 * N + 3);
    check("s2_done_seen", f_dones, 1);
    check("s3_rx_valid_with_done", f_rxv, 1'b1);
    check("s3_rx_valid_stray", f_rxv_bad, 0);
    check("s3_rx_byte", rx_byte, 8'h3C);
    check("s2_mosi_when_cs_high", f_mosi_bad, 0);
    idle_watch(5, hits);
    check("s2_no_extra_done", hits, 0);
    check("s3_rx_byte_held", rx_byte, 8'h3C);

    wind_speed = 8'd37;
    send_frame(1'b1);
    check("s4_snapshot_bits", f_bits, exp_frame(8'd37, 1'b0, 1'b1));
    check("s4_busy_cycles", f_busy, 16 * N + 3);
    check("s4_done_seen", f_dones, 1);
    idle_watch(60, hits);
    check("s4_start_not_queued", hits, 0);

    wind_speed = 8'hC3; water = 1'b1; too_windy = 1'b0;
    send_frame(1'b0);
    check("s4_chain_a_bits", f_bits, exp_frame(8'hC3, 1'b1, 1'b0));
    check("s4_cs_high_on_done", f_cs_done, 1'b1);
    wind_speed = 8'hFF; water = 1'b1; too_windy = 1'b1;
    send_frame(1'b0);
    check("s4_chain_b_bits", f_bits, exp_frame(8'hFF, 1'b1, 1'b1));
    check("s4_chain_b_busy", f_busy, 16 * N + 3);
    check("s4_chain_b_done", f_dones, 1);
    check("s4_chain_b_mosi_idle", f_mosi_bad, 0);

    wind_speed = 8'd37; water = 1'b0; too_windy = 1'b1;
    @(negedge ms_clk);
    start = 1'b1;
    @(negedge ms_clk);
    start = 1'b0;
    repeat (21) @(negedge ms_clk);
    check("s5_in_bit10_sclk", sclk, 1'b1);
    reset = 1'b0;
    #1;
    check("s5_rst_cs_n", cs_n, 1'b1);
    check("s5_rst_sclk", sclk, 1'b0);
    check("s5_rst_mosi", mosi, 1'b0);
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_rx_byte", rx_byte, 8'h00);
    idle_watch(4, hits);
    check("s5_no_done", hits, 0);
    reset = 1'b1;
    @(negedge ms_clk);
    send_frame(1'b0);
    check("s5_clean_bits", f_bits, exp_frame(8'd37, 1'b0, 1'b1));
    check("s5_clean_busy", f_busy, 16 * N + 3);
    check("s5_clean_rx_byte", rx_byte, 8'h3C);

    b3 = 0; d3 = 0; r0 = -1; r1 = -1; nr = 0; m3 = 0; p3 = 1'b0;
    start3 = 1'b1;
    @(negedge ms_clk);
    start3 = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (busy3) b3++;
      if (cs_n3 && mosi3) m3++;
      if (sclk3 && !p3) begin
        if (nr == 0) r0 = cyc;
        if (nr == 1) r1 = cyc;
        nr++;
      end
      p3 = sclk3;
      if (done3) begin
        d3++;
        check("s6_rx_valid3", rx_valid3, 1'b1);
        break;
      end
      @(negedge ms_clk);
    end
    check("s6_div3_busy", b3, (16 * N + 3) * 3);
    check("s6_div3_period", r1 - r0, 6);
    check("s6_div3_edges", nr, 8 * N);
    check("s6_div3_done", d3, 1);
    check("s6_div3_rx_byte", rx_byte3, 8'h00);
    check("s6_div3_mosi_idle", m3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
